mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/wdog_counter.sv | 22 ++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encodings, grant tags
// and the default watchdog limit.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_t;

   localparam int TIMEOUT_DEF = 255;
   localparam int WDOG_W      = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; master is the arbiter's
// view, slave is the view of the surrounding pipeline and memory.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_valid;
   logic              i_stall;

   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              d_stall;

   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;

   logic              err;

   modport master (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
      output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
             mem_en, mem_wr, mem_addr, mem_wdata, err
   );

   modport slave (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
      input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
             mem_en, mem_wr, mem_addr, mem_wdata, err
   );
endinterface

// File: rtl/wdog_counter.sv
// Wait-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at TERM.
module wdog_counter #(
   parameter int         W    = 8,
   parameter logic [W-1:0] TERM = '1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end

   assign tc = en && (cnt == TERM);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto a single-outstanding unified memory,
// with data priority, fetch anti-starvation and a timeout abort.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.master bus
);
   localparam logic [WDOG_W-1:0] WDOG_TERM = WDOG_W'(TIMEOUT - 1);

   arb_state_t        state, state_n;
   gnt_t              last_gnt;
   logic              i_pend, d_pend;
   logic              grant_i, grant_d, done, tmo, wdog_tc;
   logic              i_valid_q, d_valid_q, mem_en_q, mem_wr_q, err_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

   // A requester still holding req in its valid cycle is already served.
   assign i_pend = bus.i_req & ~i_valid_q;
   assign d_pend = bus.d_req & ~d_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      grant_i = 1'b0;
      grant_d = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      case (state)
         IDLE: begin
            if (d_pend && !(last_gnt == GNT_D && i_pend)) begin
               state_n = D_BUSY;
               grant_d = 1'b1;
            end else if (i_pend) begin
               state_n = I_BUSY;
               grant_i = 1'b1;
            end
         end
         I_BUSY, D_BUSY: begin
            if (bus.mem_valid) begin
               done    = 1'b1;
               state_n = IDLE;
            end else if (wdog_tc) begin
               tmo     = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   wdog_counter #(.W(WDOG_W), .TERM(WDOG_TERM)) u_wdog (
      .clk (clk),
      .rst (rst),
      .clr (grant_i | grant_d),
      .en  (state != IDLE),
      .tc  (wdog_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt    <= GNT_I;
         i_valid_q   <= 1'b0;
         d_valid_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         mem_en_q  <= grant_i | grant_d;
         i_valid_q <= (state == I_BUSY) && (done || tmo);
         d_valid_q <= (state == D_BUSY) && (done || tmo);
         if (grant_d) begin
            mem_addr_q  <= bus.d_addr;
            mem_wr_q    <= bus.d_wr;
            mem_wdata_q <= bus.d_wdata;
         end else if (grant_i) begin
            mem_addr_q  <= bus.i_addr;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
         end
         if (done && state == I_BUSY)             i_rdata_q <= bus.mem_rdata;
         if (done && state == D_BUSY && !mem_wr_q) d_rdata_q <= bus.mem_rdata;
         if (tmo) err_q <= 1'b1;
         if (done || tmo) last_gnt <= (state == D_BUSY) ? GNT_D : GNT_I;
      end
   end

   assign bus.i_rdata   = i_rdata_q;
   assign bus.i_valid   = i_valid_q;
   assign bus.i_stall   = bus.i_req & ~i_valid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.d_stall   = bus.d_req & ~d_valid_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory responder.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int LAT = 3;

   logic clk, rst;
   mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int          n_chk = 0, n_pass = 0;
   logic [15:0] mdata;
   bit          mute;
   int          fmv_req = 0, fmv_ack = 0;
   int          mcnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: answers each mem_en LAT cycles later, or injects a
   // stray mem_valid when asked.
   initial begin
      bus.mem_valid = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_valid = 1'b0;
         if (mcnt == 1) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = mdata;
         end
         if (mcnt != 0) mcnt--;
         if (fmv_req != fmv_ack) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = 16'hBEEF;
            fmv_ack       = fmv_req;
         end
         if (bus.mem_en && !mute) mcnt = LAT;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input bit dside, input int bound, output int n);
      n = 0;
      while (!(dside ? bus.d_valid : bus.i_valid) && n < bound) begin
         tick();
         n++;
      end
      if (!(dside ? bus.d_valid : bus.i_valid)) chk("wait_bound", 0, 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},  32'(dut.state), 32'(IDLE));
      chk({tag, "_ivalid"}, 32'(bus.i_valid), 0);
      chk({tag, "_dvalid"}, 32'(bus.d_valid), 0);
      chk({tag, "_mem_en"}, 32'(bus.mem_en), 0);
      chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 0);
      chk({tag, "_err"},    32'(bus.err), 0);
      chk({tag, "_irdata"}, 32'(bus.i_rdata), 0);
      chk({tag, "_drdata"}, 32'(bus.d_rdata), 0);
      chk({tag, "_maddr"},  32'(bus.mem_addr), 0);
      chk({tag, "_mwdata"}, 32'(bus.mem_wdata), 0);
   endtask

   initial begin
      int n;
      bit saw;
      rst = 1'b1;
      mute = 1'b0;
      mdata = '0;
      bus.i_req = 0; bus.i_addr = '0;
      bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
      tick(); tick();
      chk_reset_vals("rst");
      rst = 1'b0;
      tick();

      // Uncontended fetch: mem_en at cycle 1, i_valid at cycle 5
      bus.i_req = 1; bus.i_addr = 16'h0010; mdata = 16'hA5A5;
      tick();
      chk("f_mem_en", 32'(bus.mem_en), 1);
      chk("f_maddr",  32'(bus.mem_addr), 32'h0010);
      chk("f_mwr",    32'(bus.mem_wr), 0);
      chk("f_mwdata", 32'(bus.mem_wdata), 0);
      chk("f_istall", 32'(bus.i_stall), 1);
      wait_valid(0, 20, n);
      chk("f_lat",    n, 4);
      chk("f_irdata", 32'(bus.i_rdata), 32'hA5A5);
      chk("f_istall_v", 32'(bus.i_stall), 0);
      bus.i_req = 0;
      tick();
      chk("f_ivalid_1cyc", 32'(bus.i_valid), 0);
      chk("f_no_regrant",  32'(bus.mem_en), 0);

      // Both request: D first, then I
      bus.i_req = 1; bus.i_addr = 16'h0020;
      bus.d_req = 1; bus.d_addr = 16'h0200; mdata = 16'h1111;
      tick();
      chk("c1_maddr", 32'(bus.mem_addr), 32'h0200);
      chk("c1_istall", 32'(bus.i_stall), 1);
      wait_valid(1, 20, n);
      chk("c1_drdata", 32'(bus.d_rdata), 32'h1111);
      bus.d_req = 0; mdata = 16'h2222;
      tick();
      chk("c2_mem_en", 32'(bus.mem_en), 1);
      chk("c2_maddr",  32'(bus.mem_addr), 32'h0020);
      wait_valid(0, 20, n);
      chk("c2_irdata", 32'(bus.i_rdata), 32'h2222);
      bus.i_req = 0;
      tick();

      // D alone, leaving D as the last completed grant
      bus.d_req = 1; bus.d_addr = 16'h0204; mdata = 16'h3333;
      tick();
      chk("c3_maddr", 32'(bus.mem_addr), 32'h0204);
      wait_valid(1, 20, n);
      chk("c3_drdata", 32'(bus.d_rdata), 32'h3333);
      bus.d_req = 0;
      tick();

      // Both again: I wins once, then D
      bus.i_req = 1; bus.i_addr = 16'h0030;
      bus.d_req = 1; bus.d_addr = 16'h0208; mdata = 16'h4444;
      tick();
      chk("c4_maddr",  32'(bus.mem_addr), 32'h0030);
      chk("c4_dstall", 32'(bus.d_stall), 1);
      wait_valid(0, 20, n);
      chk("c4_irdata", 32'(bus.i_rdata), 32'h4444);
      bus.i_req = 0; mdata = 16'h5555;
      tick();
      chk("c5_maddr", 32'(bus.mem_addr), 32'h0208);
      wait_valid(1, 20, n);
      chk("c5_drdata", 32'(bus.d_rdata), 32'h5555);
      bus.d_req = 0;
      tick();

      // Store leaves d_rdata untouched
      bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0300; bus.d_wdata = 16'h1234;
      mdata = 16'hDEAD;
      tick();
      chk("s_mem_en", 32'(bus.mem_en), 1);
      chk("s_mwr",    32'(bus.mem_wr), 1);
      chk("s_mwdata", 32'(bus.mem_wdata), 32'h1234);
      chk("s_maddr",  32'(bus.mem_addr), 32'h0300);
      tick();
      chk("s_en_pulse", 32'(bus.mem_en), 0);
      chk("s_wd_held",  32'(bus.mem_wdata), 32'h1234);
      wait_valid(1, 20, n);
      chk("s_lat",    n, 3);
      chk("s_drdata", 32'(bus.d_rdata), 32'h5555);
      bus.d_req = 0; bus.d_wr = 0;
      tick();

      // Stray mem_valid in IDLE
      fmv_req++;
      tick(); tick();
      chk("idle_ivalid", 32'(bus.i_valid), 0);
      chk("idle_dvalid", 32'(bus.d_valid), 0);
      chk("idle_irdata", 32'(bus.i_rdata), 32'h4444);
      chk("idle_drdata", 32'(bus.d_rdata), 32'h5555);
      chk("idle_state",  32'(dut.state), 32'(IDLE));
      chk("idle_mem_en", 32'(bus.mem_en), 0);

      // Memory never answers: abort after 255 busy cycles
      mute = 1;
      bus.i_req = 1; bus.i_addr = 16'h0040;
      tick();
      chk("t_mem_en", 32'(bus.mem_en), 1);
      chk("t_err_pre", 32'(bus.err), 0);
      wait_valid(0, 400, n);
      chk("t_lat",    n, 255);
      chk("t_err",    32'(bus.err), 1);
      chk("t_irdata", 32'(bus.i_rdata), 32'h4444);
      bus.i_req = 0;
      tick();
      chk("t_state",  32'(dut.state), 32'(IDLE));
      chk("t_ivalid", 32'(bus.i_valid), 0);
      repeat (5) tick();
      chk("t_err_sticky", 32'(bus.err), 1);
      mute = 0;

      // Reset in D_BUSY, memory answers after release
      bus.d_req = 1; bus.d_addr = 16'h0500; mdata = 16'h6666;
      tick();
      chk("r_mem_en", 32'(bus.mem_en), 1);
      tick();
      chk("r_busy", 32'(dut.state), 32'(D_BUSY));
      rst = 1'b1;
      #1;
      chk_reset_vals("r_async");
      bus.d_req = 0;
      tick();
      rst = 1'b0;
      saw = 0;
      repeat (5) begin
         tick();
         saw |= bus.d_valid | bus.i_valid;
      end
      chk("r_no_valid", 32'(saw), 0);
      chk_reset_vals("r_after");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
